// File: rtl/olimp_pkg.sv
// Shared types and constants for the OLIMP vector-MAC sequencer.
// The saturating add helper is only referenced when OLIMP_SAT_EN is defined.
package olimp_pkg;

    localparam int unsigned OLIMP_MAC_LAT = 3;
    localparam int unsigned OLIMP_ACC_W   = 32;
    localparam int unsigned OLIMP_DATA_W  = 64;
    localparam int unsigned OLIMP_COEF_W  = 128;

    localparam logic [OLIMP_ACC_W-1:0] OLIMP_SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [OLIMP_ACC_W-1:0] OLIMP_SAT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } olimp_state_e;

    typedef struct packed {
        logic                   sat;
        logic [OLIMP_ACC_W-1:0] val;
    } olimp_acc_t;

    // Signed add that clamps on overflow; once clamped the lane holds its value.
    function automatic olimp_acc_t olimp_sat_add(olimp_acc_t cur, logic [OLIMP_ACC_W-1:0] add);
        olimp_acc_t             res;
        logic [OLIMP_ACC_W-1:0] sum;
        sum     = cur.val + add;
        res.sat = cur.sat;
        res.val = sum;
        if (cur.sat) begin
            res.val = cur.val;
        end else if ((cur.val[OLIMP_ACC_W-1] == add[OLIMP_ACC_W-1]) &&
                     (sum[OLIMP_ACC_W-1] != cur.val[OLIMP_ACC_W-1])) begin
            res.sat = 1'b1;
            res.val = add[OLIMP_ACC_W-1] ? OLIMP_SAT_MIN : OLIMP_SAT_MAX;
        end
        return res;
    endfunction

endpackage

// File: rtl/olimp_vec_seq_if.sv
// Beat input stream and result output handshake of the OLIMP sequencer.
interface olimp_vec_seq_if;
    import olimp_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [OLIMP_DATA_W-1:0] in_data;
    logic [OLIMP_COEF_W-1:0] in_coef;
    logic                    out_valid;
    logic                    out_ready;
    logic [OLIMP_ACC_W-1:0]  out_acc0;
    logic [OLIMP_ACC_W-1:0]  out_acc1;

    modport master (
        output in_valid, in_data, in_coef, out_ready,
        input  in_ready, out_valid, out_acc0, out_acc1
    );

    modport slave (
        input  in_valid, in_data, in_coef, out_ready,
        output in_ready, out_valid, out_acc0, out_acc1
    );

endinterface

// File: rtl/olimp_vld_pipe.sv
// DEPTH-deep 1-bit shift line marking which MAC pipeline slots carry a real beat.
module olimp_vld_pipe #(
    parameter int unsigned DEPTH = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_din,
    output logic o_tap
);

    logic [DEPTH-1:0] r_line;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_line <= '0;
        end else begin
            r_line[0] <= i_din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_line[i] <= r_line[i-1];
            end
        end
    end

    assign o_tap = r_line[DEPTH-1];

endmodule

// File: rtl/olimp_vec_seq.sv
// Sequencer between stream fabric and VEC-8U8-16I8-2S32 MAC: issues beats, tracks latency, sums lanes.
// Build option OLIMP_SAT_EN: sticky saturating accumulation instead of 32-bit wrap.
module olimp_vec_seq
    import olimp_pkg::*;
#(
    parameter int unsigned MAC_LAT = OLIMP_MAC_LAT,
    parameter int unsigned LEN_W   = 16
) (
    input  logic                    clk_dsp,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        cfg_len,
    output logic                    busy,
    olimp_vec_seq_if.slave          strm,
    output logic [OLIMP_DATA_W-1:0] mac_data,
    output logic [OLIMP_COEF_W-1:0] mac_coef,
    input  logic [OLIMP_ACC_W-1:0]  mac_acc0,
    input  logic [OLIMP_ACC_W-1:0]  mac_acc1,
    output logic                    done
);

    olimp_state_e           r_state;
    olimp_state_e           w_state_nxt;
    logic [LEN_W-1:0]       r_len;
    logic [LEN_W-1:0]       r_issued;
    logic [LEN_W-1:0]       r_retired;
    logic [OLIMP_ACC_W-1:0] r_acc0;
    logic [OLIMP_ACC_W-1:0] r_acc1;
    logic [OLIMP_ACC_W-1:0] w_acc0_nxt;
    logic [OLIMP_ACC_W-1:0] w_acc1_nxt;
    logic                   r_busy;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   w_accept;
    logic                   w_start_acc;
    logic                   w_retire;
    logic                   w_last_accept;
    logic                   w_last_retire;

    assign w_accept      = r_in_ready & strm.in_valid;
    assign w_start_acc   = (r_state == IDLE) & start;
    assign w_last_accept = w_accept && (r_issued == (r_len - LEN_W'(1)));
    assign w_last_retire = w_retire && (r_retired == (r_len - LEN_W'(1)));

    olimp_vld_pipe #(
        .DEPTH (MAC_LAT)
    ) u_vld_pipe (
        .i_clk (clk_dsp),
        .i_rst (rst),
        .i_clr (w_start_acc),
        .i_din (w_accept),
        .o_tap (w_retire)
    );

    always_ff @(posedge clk_dsp) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = (cfg_len == '0) ? OUT : FEED;
            FEED:    if (w_last_accept) w_state_nxt = DRAIN;
            DRAIN:   if (w_last_retire) w_state_nxt = OUT;
            OUT:     if (strm.out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with r_state.
    always_ff @(posedge clk_dsp) begin
        if (rst) begin
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_busy      <= (w_state_nxt != IDLE);
            r_in_ready  <= (w_state_nxt == FEED);
            r_out_valid <= (w_state_nxt == OUT);
        end
    end

`ifdef OLIMP_SAT_EN
    logic       r_sat0;
    logic       r_sat1;
    olimp_acc_t w_sum0;
    olimp_acc_t w_sum1;

    assign w_sum0     = olimp_sat_add(olimp_acc_t'({r_sat0, r_acc0}), mac_acc0);
    assign w_sum1     = olimp_sat_add(olimp_acc_t'({r_sat1, r_acc1}), mac_acc1);
    assign w_acc0_nxt = w_sum0.val;
    assign w_acc1_nxt = w_sum1.val;

    always_ff @(posedge clk_dsp) begin
        if (rst || w_start_acc) begin
            r_sat0 <= 1'b0;
            r_sat1 <= 1'b0;
        end else if (w_retire) begin
            r_sat0 <= w_sum0.sat;
            r_sat1 <= w_sum1.sat;
        end
    end
`else
    assign w_acc0_nxt = r_acc0 + mac_acc0;
    assign w_acc1_nxt = r_acc1 + mac_acc1;
`endif

    // Job length, issue/retire counts and running dot products.
    always_ff @(posedge clk_dsp) begin
        if (rst) begin
            r_len     <= '0;
            r_issued  <= '0;
            r_retired <= '0;
            r_acc0    <= '0;
            r_acc1    <= '0;
        end else if (w_start_acc) begin
            r_len     <= cfg_len;
            r_issued  <= '0;
            r_retired <= '0;
            r_acc0    <= '0;
            r_acc1    <= '0;
        end else begin
            if (w_accept) begin
                r_issued <= r_issued + LEN_W'(1);
            end
            if (w_retire) begin
                r_retired <= r_retired + LEN_W'(1);
                r_acc0    <= w_acc0_nxt;
                r_acc1    <= w_acc1_nxt;
            end
        end
    end

    // MAC inputs and done follow the handshakes in the same cycle.
    assign mac_data = w_accept ? strm.in_data : '0;
    assign mac_coef = w_accept ? strm.in_coef : '0;
    assign done     = (r_state == OUT) & strm.out_ready;

    assign busy           = r_busy;
    assign strm.in_ready  = r_in_ready;
    assign strm.out_valid = r_out_valid;
    assign strm.out_acc0  = r_acc0;
    assign strm.out_acc1  = r_acc1;

endmodule

// File: tb/tb_olimp_vec_seq.sv
// Bench for olimp_vec_seq: behavioural 3-cycle MAC, randomized jobs vs. a dot-product reference.
// Honours OLIMP_SAT_EN in the reference so either build can be checked.
module tb_olimp_vec_seq;

    localparam int MAC_LAT = 3;

    logic          clk_dsp = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   cfg_len;
    logic          busy;
    logic          done;
    logic [63:0]   mac_data;
    logic [127:0]  mac_coef;
    logic [31:0]   mac_acc0;
    logic [31:0]   mac_acc1;
    logic [31:0]   m0 [MAC_LAT];
    logic [31:0]   m1 [MAC_LAT];
    logic [63:0]   jd [$];
    logic [127:0]  jc [$];
    int            n_checks = 0;
    int            n_err = 0;

    olimp_vec_seq_if ifc ();

    olimp_vec_seq #(
        .MAC_LAT (MAC_LAT),
        .LEN_W   (16)
    ) dut (
        .clk_dsp  (clk_dsp),
        .rst      (rst),
        .start    (start),
        .cfg_len  (cfg_len),
        .busy     (busy),
        .strm     (ifc),
        .mac_data (mac_data),
        .mac_coef (mac_coef),
        .mac_acc0 (mac_acc0),
        .mac_acc1 (mac_acc1),
        .done     (done)
    );

    always #5 clk_dsp = ~clk_dsp;

    // Lane dot product: 8 unsigned data bytes times 8 signed coef bytes of that lane.
    function automatic int lane_dot(logic [63:0] d, logic [127:0] c, int lane);
        int s = 0;
        for (int i = 0; i < 8; i++) begin
            logic [7:0]        db;
            logic signed [7:0] cb;
            db = d[8*i +: 8];
            cb = c[8*(8*lane+i) +: 8];
            s += int'(db) * int'(cb);
        end
        return s;
    endfunction

    // Behavioural MAC: result of the inputs seen at an edge appears MAC_LAT cycles later.
    always @(posedge clk_dsp) begin
        if (rst) begin
            for (int i = 0; i < MAC_LAT; i++) begin
                m0[i] <= '0;
                m1[i] <= '0;
            end
        end else begin
            m0[0] <= lane_dot(mac_data, mac_coef, 0);
            m1[0] <= lane_dot(mac_data, mac_coef, 1);
            for (int i = 1; i < MAC_LAT; i++) begin
                m0[i] <= m0[i-1];
                m1[i] <= m1[i-1];
            end
        end
    end
    assign mac_acc0 = m0[MAC_LAT-1];
    assign mac_acc1 = m1[MAC_LAT-1];

    // Reference job result from the queued beats.
    function automatic logic [31:0] ref_acc(int lane);
        longint s = 0;
        bit     sat = 0;
        for (int b = 0; b < jd.size(); b++) begin
`ifdef OLIMP_SAT_EN
            if (!sat) begin
                s += longint'(lane_dot(jd[b], jc[b], lane));
                if (s > 64'sd2147483647) begin
                    s = 64'sd2147483647;
                    sat = 1;
                end else if (s < -64'sd2147483648) begin
                    s = -64'sd2147483648;
                    sat = 1;
                end
            end
`else
            s += longint'(lane_dot(jd[b], jc[b], lane));
`endif
        end
        return s[31:0];
    endfunction

    function automatic void fill(int len, bit rnd, logic [7:0] db, logic [7:0] cb);
        jd.delete();
        jc.delete();
        for (int b = 0; b < len; b++) begin
            if (rnd) begin
                jd.push_back({$urandom, $urandom});
                jc.push_back({$urandom, $urandom, $urandom, $urandom});
            end else begin
                jd.push_back({8{db}});
                jc.push_back({16{cb}});
            end
        end
    endfunction

    // Drives one job from a negedge; returns at the negedge where out_valid is first seen.
    // mode 0: always valid, 1: valid pattern 1,0,0,..., 2: random valid.
    task automatic run_job(input int len, input int mode, output logic [31:0] g0,
                           output logic [31:0] g1, output int lat, output int nacc,
                           output int nrdy, output bit to);
        int  idx = 0;
        int  guard = 0;
        bit  v;
        nacc = 0;
        nrdy = 0;
        start = 1'b1;
        cfg_len = 16'(len);
        @(negedge clk_dsp);
        start = 1'b0;
        lat = 1;
        while (idx < len && guard < len * 4 + 50) begin
            if (mode == 0) v = 1'b1;
            else if (mode == 1) v = (guard % 3 == 0);
            else v = 1'($urandom_range(0, 1));
            ifc.in_valid = v;
            ifc.in_data = jd[idx];
            ifc.in_coef = jc[idx];
            if (ifc.in_ready) nrdy++;
            if (v && ifc.in_ready) begin
                idx++;
                nacc++;
            end
            @(negedge clk_dsp);
            guard++;
            lat = 1;
        end
        ifc.in_valid = 1'b0;
        ifc.in_data = '0;
        ifc.in_coef = '0;
        while (!ifc.out_valid && lat < 64) begin
            if (ifc.in_ready) nrdy++;
            @(negedge clk_dsp);
            lat++;
        end
        to = !ifc.out_valid;
        g0 = ifc.out_acc0;
        g1 = ifc.out_acc1;
    endtask

    task automatic take_result(output logic d);
        ifc.out_ready = 1'b1;
        #1;
        d = done;
        @(negedge clk_dsp);
        ifc.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk_dsp);
        n_checks++;
        if ({busy, ifc.in_ready, ifc.out_valid, done} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 0000", {busy, ifc.in_ready, ifc.out_valid, done});
        end
        rst = 1'b0;
        @(negedge clk_dsp);
        n_checks++;
        if ({ifc.out_acc0, ifc.out_acc1, mac_data} !== '0) begin
            n_err++;
            $display("FAIL reset_data: acc0 %h acc1 %h mac_data %h want 0", ifc.out_acc0, ifc.out_acc1, mac_data);
        end
    endtask

    task automatic test_single();
        logic [31:0] g0, g1;
        int lat, nacc, nrdy;
        bit to;
        logic d;
        fill(1, 0, 8'h01, 8'h01);
        run_job(1, 0, g0, g1, lat, nacc, nrdy, to);
        n_checks++;
        if (to) begin n_err++; $display("FAIL single_timeout: out_valid never rose"); end
        n_checks++;
        if ({g0, g1} !== {32'd8, 32'd8}) begin
            n_err++;
            $display("FAIL single_acc: got %h/%h want 8/8", g0, g1);
        end
        n_checks++;
        if (lat !== MAC_LAT + 1) begin n_err++; $display("FAIL single_latency: got %0d want %0d", lat, MAC_LAT + 1); end
        take_result(d);
        n_checks++;
        if (d !== 1'b1) begin n_err++; $display("FAIL single_done: got %b want 1", d); end
        n_checks++;
        if (busy !== 1'b0 || ifc.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_idle: busy %b out_valid %b want 0 0", busy, ifc.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] g0, g1;
        int lat, nacc, nrdy;
        bit to;
        logic d;
        fill(4, 0, 8'h02, 8'hFF);
        run_job(4, 0, g0, g1, lat, nacc, nrdy, to);
        n_checks++;
        if (to || {g0, g1} !== {32'hFFFF_FFC0, 32'hFFFF_FFC0}) begin
            n_err++;
            $display("FAIL b2b_acc: got %h/%h to=%0d want ffffffc0/ffffffc0", g0, g1, to);
        end
        n_checks++;
        if (nrdy !== 4) begin n_err++; $display("FAIL b2b_ready_cycles: got %0d want 4", nrdy); end
        n_checks++;
        if (lat !== MAC_LAT + 1) begin n_err++; $display("FAIL b2b_latency: got %0d want %0d", lat, MAC_LAT + 1); end
        take_result(d);
        n_checks++;
        if (d !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b want 1", d); end
    endtask

    task automatic test_bubbles();
        logic [31:0] g0, g1;
        int lat, nacc, nrdy;
        bit to;
        logic d;
        fill(4, 0, 8'h02, 8'hFF);
        run_job(4, 1, g0, g1, lat, nacc, nrdy, to);
        n_checks++;
        if (to || {g0, g1} !== {32'hFFFF_FFC0, 32'hFFFF_FFC0}) begin
            n_err++;
            $display("FAIL bubble_acc: got %h/%h to=%0d want ffffffc0/ffffffc0", g0, g1, to);
        end
        n_checks++;
        if (dut.r_retired !== 16'd4 || nacc !== 4) begin
            n_err++;
            $display("FAIL bubble_retires: retired %0d accepts %0d want 4 4", dut.r_retired, nacc);
        end
        n_checks++;
        if (lat !== MAC_LAT + 1) begin n_err++; $display("FAIL bubble_latency: got %0d want %0d", lat, MAC_LAT + 1); end
        take_result(d);
        n_checks++;
        if (d !== 1'b1) begin n_err++; $display("FAIL bubble_done: got %b want 1", d); end
    endtask

    task automatic test_out_hold();
        logic [31:0] g0, g1, e0, e1;
        int lat, nacc, nrdy;
        bit to;
        logic d;
        fill(2, 1, 8'h00, 8'h00);
        e0 = ref_acc(0);
        e1 = ref_acc(1);
        run_job(2, 0, g0, g1, lat, nacc, nrdy, to);
        n_checks++;
        if (to || {g0, g1} !== {e0, e1}) begin
            n_err++;
            $display("FAIL hold_acc: got %h/%h to=%0d want %h/%h", g0, g1, to, e0, e1);
        end
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            cfg_len = 16'd3;
            n_checks++;
            if (ifc.out_valid !== 1'b1 || {ifc.out_acc0, ifc.out_acc1} !== {e0, e1} || done !== 1'b0) begin
                n_err++;
                $display("FAIL hold_cycle%0d: valid %b acc %h/%h done %b want 1 %h/%h 0",
                         i, ifc.out_valid, ifc.out_acc0, ifc.out_acc1, done, e0, e1);
            end
            @(negedge clk_dsp);
        end
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL hold_start_ignored: busy %b valid %b in_ready %b want 1 1 0", busy, ifc.out_valid, ifc.in_ready);
        end
        take_result(d);
        n_checks++;
        if (d !== 1'b1) begin n_err++; $display("FAIL hold_done: got %b want 1", d); end
        n_checks++;
        if ({busy, ifc.out_valid, ifc.in_ready, done} !== 4'b0) begin
            n_err++;
            $display("FAIL hold_idle: busy/valid/ready/done %b want 0000", {busy, ifc.out_valid, ifc.in_ready, done});
        end
    endtask

    task automatic test_zero_len();
        logic [31:0] g0, g1;
        int lat, nacc, nrdy;
        bit to;
        logic d;
        fill(0, 0, 8'h00, 8'h00);
        run_job(0, 0, g0, g1, lat, nacc, nrdy, to);
        n_checks++;
        if (to || lat > 2 || nrdy !== 0) begin
            n_err++;
            $display("FAIL zero_len_timing: lat %0d ready_cycles %0d to=%0d want <=2 0 0", lat, nrdy, to);
        end
        n_checks++;
        if ({g0, g1} !== 64'd0) begin n_err++; $display("FAIL zero_len_acc: got %h/%h want 0/0", g0, g1); end
        take_result(d);
        n_checks++;
        if (d !== 1'b1) begin n_err++; $display("FAIL zero_len_done: got %b want 1", d); end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        fill(8, 1, 8'h00, 8'h00);
        start = 1'b1;
        cfg_len = 16'd8;
        @(negedge clk_dsp);
        start = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.in_data = jd[0];
        ifc.in_coef = jc[0];
        @(negedge clk_dsp);
        ifc.in_data = jd[1];
        ifc.in_coef = jc[1];
        rst = 1'b1;
        @(negedge clk_dsp);
        rst = 1'b0;
        n_checks++;
        if ({busy, ifc.in_ready, ifc.out_valid, done} !== 4'b0 ||
            {ifc.out_acc0, ifc.out_acc1, mac_data, mac_coef} !== '0) begin
            n_err++;
            $display("FAIL midrst_outputs: flags %b acc %h/%h mac %h want all 0",
                     {busy, ifc.in_ready, ifc.out_valid, done}, ifc.out_acc0, ifc.out_acc1, mac_data);
        end
        ifc.in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (ifc.out_valid || busy) seen = 1;
            @(negedge clk_dsp);
        end
        n_checks++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_no_result: got activity 1 want 0"); end
    endtask

    task automatic test_random();
        logic [31:0] g0, g1, e0, e1;
        int lat, nacc, nrdy, len;
        bit to;
        logic d;
        for (int j = 0; j < 6; j++) begin
            len = $urandom_range(1, 12);
            fill(len, 1, 8'h00, 8'h00);
            e0 = ref_acc(0);
            e1 = ref_acc(1);
            run_job(len, 2, g0, g1, lat, nacc, nrdy, to);
            n_checks++;
            if (to || {g0, g1} !== {e0, e1}) begin
                n_err++;
                $display("FAIL rand%0d_acc: len %0d got %h/%h to=%0d want %h/%h", j, len, g0, g1, to, e0, e1);
            end
            n_checks++;
            if (lat !== MAC_LAT + 1 || nacc !== len) begin
                n_err++;
                $display("FAIL rand%0d_timing: lat %0d accepts %0d want %0d %0d", j, lat, nacc, MAC_LAT + 1, len);
            end
            take_result(d);
            n_checks++;
            if (d !== 1'b1) begin n_err++; $display("FAIL rand%0d_done: got %b want 1", j, d); end
        end
    endtask

    task automatic test_long();
        logic [31:0] g0, g1, e0, e1;
        int lat, nacc, nrdy;
        bit to;
        logic d;
        fill(40000, 0, 8'h7F, 8'h7F);
        e0 = ref_acc(0);
        e1 = ref_acc(1);
        run_job(40000, 0, g0, g1, lat, nacc, nrdy, to);
        n_checks++;
        if (to || {g0, g1} !== {e0, e1}) begin
            n_err++;
            $display("FAIL long_acc: got %h/%h to=%0d want %h/%h", g0, g1, to, e0, e1);
        end
        take_result(d);
        n_checks++;
        if (d !== 1'b1) begin n_err++; $display("FAIL long_done: got %b want 1", d); end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cfg_len = '0;
        ifc.in_valid = 1'b0;
        ifc.in_data = '0;
        ifc.in_coef = '0;
        ifc.out_ready = 1'b0;
        @(negedge clk_dsp);
        test_reset();
        test_single();
        test_back_to_back();
        test_bubbles();
        test_out_hold();
        test_zero_len();
        test_reset_mid();
        test_random();
        test_long();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
